// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 block.
// Holds the CP0 register numbers, the Status/Cause bit positions, the ExcCode
// values driven by the pipeline, and the reset/constant register images.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;
  localparam logic [7:0]  IM_RESET     = 8'hFF;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   count_we        load Count from wdata and restart the prescaler
//   compare_we      load Compare from wdata and clear the timer interrupt
//   wdata           write data shared by both strobes
//   count, compare  current register values
//   ti              timer interrupt flag (Cause.TI / IP[7] source)
module cp0_timer #(
  parameter int WIDTH     = 32,
  parameter int COUNT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_we,
  input  logic             compare_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic             ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             count_moved;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    tick        = (div == DIV_LAST);
    count_next  = count;
    count_moved = 1'b0;
    if (count_we) begin
      count_next  = wdata;
      count_moved = 1'b1;
    end else if (tick) begin
      count_next  = count + WIDTH'(1);
      count_moved = 1'b1;
    end
  end

  // A match is only taken on an edge where Count actually takes a new value,
  // so a Compare equal to a stalled Count does not re-arm the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_next;
      if (count_we || tick) div <= '0;
      else                  div <= div + 1'b1;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count_moved && (count_next == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_core.sv
// cp0_core: MIPS coprocessor 0 with Count/Compare timer and synchronised
// hardware interrupts.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   hw_int                         asynchronous level interrupt lines
//   raddr / rdata                  combinational MFC0 read
//   mtc0_we, waddr, wdata          MTC0 commit
//   exc_valid, exc_code, exc_bd,
//   exc_pc, exc_badv_we, exc_badv  exception commit
//   eret_valid                     ERET commit
//   int_req                        registered interrupt request
//   redirect_valid, redirect_pc    one-cycle pipeline redirect
//   status_o, cause_o, epc_o       register views for the pipeline
module cp0_core
  import cp0_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          HW_IRQ_NUM  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] PRID_VALUE  = 32'h0000_4220,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_IRQ_NUM-1:0] hw_int,
  input  logic [4:0]            raddr,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  mtc0_we,
  input  logic [4:0]            waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [WIDTH-1:0]      exc_pc,
  input  logic                  exc_badv_we,
  input  logic [WIDTH-1:0]      exc_badv,
  input  logic                  eret_valid,
  output logic                  int_req,
  output logic                  redirect_valid,
  output logic [WIDTH-1:0]      redirect_pc,
  output logic [WIDTH-1:0]      status_o,
  output logic [WIDTH-1:0]      cause_o,
  output logic [WIDTH-1:0]      epc_o
);

  logic [7:0]       im;
  logic             exl;
  logic             ie;
  logic             bd;
  logic [1:0]       sw_ip;
  logic [4:0]       exc_code_q;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] badvaddr;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] compare;
  logic             ti;
  logic [5:0]       hw_ip;
  logic [7:0]       ip;
  logic [31:0]      status_w;
  logic [31:0]      cause_w;

  logic [HW_IRQ_NUM-1:0] sync_p [SYNC_STAGES];

  // Commit priority: exception, then ERET, then MTC0.
  logic do_exc, do_eret, do_mtc0;
  assign do_exc  = exc_valid;
  assign do_eret = eret_valid & ~exc_valid;
  assign do_mtc0 = mtc0_we & ~exc_valid & ~eret_valid;

  cp0_timer #(
    .WIDTH     (WIDTH),
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (do_mtc0 && (waddr == CP0_COUNT)),
    .compare_we (do_mtc0 && (waddr == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // hw_int synchroniser: stage 0 samples the asynchronous lines
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // Synchronised lines map onto IP[7:2]; line 5 shares IP[7] with the timer.
  always_comb begin
    hw_ip = '0;
    hw_ip[HW_IRQ_NUM-1:0] = sync_p[SYNC_STAGES-1];
  end

  assign ip       = {ti | hw_ip[5], hw_ip[4:0], sw_ip};
  assign status_w = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause_w  = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

  assign status_o = WIDTH'(status_w);
  assign cause_o  = WIDTH'(cause_w);
  assign epc_o    = epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      im             <= IM_RESET;
      exl            <= 1'b1;
      ie             <= 1'b0;
      bd             <= 1'b0;
      sw_ip          <= '0;
      exc_code_q     <= '0;
      epc            <= '0;
      badvaddr       <= '0;
      int_req        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      int_req        <= ie & ~exl & (|(ip & im));
      redirect_valid <= do_exc | do_eret;
      if (do_exc)       redirect_pc <= WIDTH'(EXC_VECTOR);
      else if (do_eret) redirect_pc <= epc;

      if (do_exc) begin
        exc_code_q <= exc_code;
        // A nested exception keeps the original return point.
        if (!exl) begin
          epc <= exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
          bd  <= exc_bd;
        end
        exl <= 1'b1;
        if (exc_badv_we) badvaddr <= exc_badv;
      end else if (do_eret) begin
        exl <= 1'b0;
      end else if (do_mtc0) begin
        case (waddr)
          CP0_STATUS: begin
            im  <= wdata[ST_IM_LO+7:ST_IM_LO];
            exl <= wdata[ST_EXL];
            ie  <= wdata[ST_IE];
          end
          CP0_CAUSE: sw_ip <= wdata[CA_IP_LO+1:CA_IP_LO];
          CP0_EPC:   epc   <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_o;
      CP0_CAUSE:    rdata = cause_o;
      CP0_EPC:      rdata = epc;
      CP0_PRID:     rdata = WIDTH'(PRID_VALUE);
      CP0_CONFIG:   rdata = WIDTH'(CONFIG_VALUE);
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_core.sv
// tb_cp0_core: bench for cp0_core with a cycle reference model, a directed
// vector table, hand-written timer/interrupt sequences and random commits.
module tb_cp0_core;

  localparam int          COUNT_DIV = 2;
  localparam int          SYNC      = 2;
  localparam logic [31:0] PRID      = 32'h0000_4220;
  localparam logic [31:0] VEC       = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        mtc0_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic        exc_badv_we;
  logic [31:0] exc_badv;
  logic        eret_valid;
  logic        int_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  cp0_core dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .raddr(raddr), .rdata(rdata),
    .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
    .exc_pc(exc_pc), .exc_badv_we(exc_badv_we), .exc_badv(exc_badv),
    .eret_valid(eret_valid), .int_req(int_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Count is derived from the last loaded value plus elapsed cycles / COUNT_DIV.
  logic [7:0]  m_im;
  bit          m_exl, m_ie, m_bd, m_ti, m_int, m_rv;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_badv, m_load, m_cmp, m_rpc;
  int unsigned m_cyc;
  logic [5:0]  hwq[$];

  function automatic logic [31:0] m_count();
    return m_load + 32'(m_cyc / COUNT_DIV);
  endfunction

  function automatic logic [5:0] m_hw();
    if (hwq.size() >= SYNC) return hwq[0];
    return 6'd0;
  endfunction

  function automatic logic [7:0] m_ip();
    logic [5:0] h;
    h = m_hw();
    return {m_ti | h[5], h[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'd0, m_im, 8'd0} | {30'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count();
      5'd11: return m_cmp;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return PRID;
      5'd16: return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] old_count, old_cmp;
    bit new_int, mtc, moved;
    if (rst) begin
      m_im = 8'hFF; m_exl = 1; m_ie = 0; m_bd = 0; m_ti = 0; m_sw = 0;
      m_code = 0; m_epc = 0; m_badv = 0; m_load = 0; m_cyc = 0; m_cmp = 0;
      m_int = 0; m_rv = 0; m_rpc = 0;
      hwq.delete();
      return;
    end
    old_count = m_count();
    old_cmp   = m_cmp;
    new_int   = m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
    m_rv = exc_valid || eret_valid;
    if (exc_valid)       m_rpc = VEC;
    else if (eret_valid) m_rpc = m_epc;
    mtc = mtc0_we && !exc_valid && !eret_valid;
    if (exc_valid) begin
      m_code = exc_code;
      if (!m_exl) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_exl = 1;
      if (exc_badv_we) m_badv = exc_badv;
    end else if (eret_valid) begin
      m_exl = 0;
    end else if (mtc) begin
      case (waddr)
        5'd11: m_cmp = wdata;
        5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
        5'd13: m_sw = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
    end
    if (mtc && waddr == 5'd9) begin
      m_load = wdata; m_cyc = 0; moved = 1;
    end else begin
      m_cyc++;
      moved = (m_count() != old_count);
    end
    if (mtc && waddr == 5'd11)                 m_ti = 0;
    else if (moved && m_count() == old_cmp)    m_ti = 1;
    m_int = new_int;
    hwq.push_back(hw_int);
    if (hwq.size() > SYNC) void'(hwq.pop_front());
  endtask

  task automatic check_all();
    check("rdata", rdata, m_read(raddr));
    check("status", status_o, m_status());
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_epc);
    check("int_req", int_req, m_int);
    check("redirect_valid", redirect_valid, m_rv);
    check("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_strobes();
    mtc0_we = 0; exc_valid = 0; eret_valid = 0; exc_badv_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; waddr = a; wdata = d;
    step();
    clear_strobes();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;     // 0 idle, 1 mtc0, 2 exc, 3 eret, 4 exc+eret+mtc0
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
    logic        bwe;
    logic [31:0] badv;
    logic [4:0]  chk;
    logic [31:0] exp;
    logic        exp_rv;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vec(input vec_t v, input int idx);
    exc_valid   = (v.op == 2 || v.op == 4);
    eret_valid  = (v.op == 3 || v.op == 4);
    mtc0_we     = (v.op == 1 || v.op == 4);
    waddr = v.addr; wdata = v.data; exc_code = v.code; exc_bd = v.bd;
    exc_pc = v.pc; exc_badv_we = v.bwe; exc_badv = v.badv; raddr = v.chk;
    step();
    check($sformatf("vec%0d_rdata", idx), rdata, v.exp);
    check($sformatf("vec%0d_rv", idx), redirect_valid, v.exp_rv);
    if (v.exp_rv) check($sformatf("vec%0d_rpc", idx), redirect_pc, v.exp_rpc);
    clear_strobes();
  endtask

  initial begin
    bit found;
    vecs[0] = '{2, 5'd0, 32'd0, 5'd4, 1'b1, 32'h8000_1004, 1'b1, 32'h1, 5'd14, 32'h8000_1000, 1'b1, VEC};
    vecs[1] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd13, 32'h8000_0010, 1'b0, 32'd0};
    vecs[2] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd8, 32'h0000_0001, 1'b0, 32'd0};
    vecs[3] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd12, 32'h0040_8003, 1'b0, 32'd0};
    vecs[4] = '{2, 5'd0, 32'd0, 5'd8, 1'b0, 32'h0000_2000, 1'b0, 32'd0, 5'd14, 32'h8000_1000, 1'b1, VEC};
    vecs[5] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd13, 32'h8000_0020, 1'b0, 32'd0};
    vecs[6] = '{3, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd12, 32'h0040_8001, 1'b1, 32'h8000_1000};
    vecs[7] = '{4, 5'd12, 32'd0, 5'd12, 1'b0, 32'h0000_3000, 1'b0, 32'd0, 5'd12, 32'h0040_8003, 1'b1, VEC};
    vecs[8] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd14, 32'h0000_3000, 1'b0, 32'd0};
    vecs[9] = '{0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd13, 32'h0000_0030, 1'b0, 32'd0};

    rst = 1; hw_int = 0; raddr = 0; waddr = 0; wdata = 0;
    exc_code = 0; exc_bd = 0; exc_pc = 0; exc_badv = 0;
    clear_strobes();

    // Reset, then 10 idle cycles
    #2;
    step();
    rst = 0;
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_cause", cause_o, 32'd0);
    raddr = 5'd9;
    for (int i = 0; i < 10; i++) step();
    check("count_after_10", rdata, 32'd5);
    check("status_reset", status_o, 32'h0040_FF02);
    check("int_req_reset", int_req, 1'b0);
    raddr = 5'd15;
    #1;
    check("prid", rdata, PRID);

    // Timer interrupt
    mtc0(5'd11, 32'd3);
    mtc0(5'd12, 32'h0000_8001);
    raddr = 5'd9;
    mtc0(5'd9, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = cause_o[30];
    end
    check("ti_seen", found, 1'b1);
    check("ti_count", rdata, 32'd3);
    check("ti_ip7", cause_o[15], 1'b1);
    check("ti_int_before", int_req, 1'b0);
    step();
    check("ti_int_req", int_req, 1'b1);
    mtc0(5'd11, 32'd100);
    check("ti_cleared", cause_o[30], 1'b0);
    check("ip7_cleared", cause_o[15], 1'b0);
    step();
    check("ti_int_drop", int_req, 1'b0);

    // Exception / ERET / priority table
    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Hardware interrupt pulse on line 2
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'b000100;
    step();
    check("hw_ip4_s1", cause_o[12], 1'b0);
    hw_int = 6'b0;
    step();
    check("hw_ip4_s2", cause_o[12], 1'b1);
    check("hw_int_req_s2", int_req, 1'b0);
    step();
    check("hw_ip4_s3", cause_o[12], 1'b0);
    check("hw_int_req_s3", int_req, 1'b1);
    step();
    check("hw_int_req_s4", int_req, 1'b0);

    // Count wrap
    raddr = 5'd9;
    mtc0(5'd9, 32'hFFFF_FFFF);
    check("wrap_load", rdata, 32'hFFFF_FFFF);
    step();
    check("wrap_hold", rdata, 32'hFFFF_FFFF);
    step();
    check("wrap_zero", rdata, 32'd0);

    // Randomised commits against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      raddr       = 5'($urandom);
      exc_valid   = ($urandom_range(0, 15) == 0);
      eret_valid  = ($urandom_range(0, 11) == 0);
      mtc0_we     = ($urandom_range(0, 2) == 0);
      exc_code    = 5'($urandom);
      exc_bd      = 1'($urandom);
      exc_pc      = $urandom;
      exc_badv_we = 1'($urandom);
      exc_badv    = $urandom;
      r = $urandom_range(0, 7);
      case (r)
        0: begin waddr = 5'd9;  wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20)); end
        1: begin waddr = 5'd11; wdata = m_count() + 32'($urandom_range(0, 6)); end
        2: begin waddr = 5'd12; wdata = $urandom; end
        3: begin waddr = 5'd13; wdata = $urandom; end
        4: begin waddr = 5'd14; wdata = $urandom; end
        5: begin waddr = 5'd8;  wdata = $urandom; end
        6: begin waddr = 5'd16; wdata = $urandom; end
        default: begin waddr = 5'($urandom); wdata = $urandom; end
      endcase
      step();
    end
    clear_strobes();
    rst = 0;
    step();

    // Reset wins over a simultaneous exception
    rst = 1; exc_valid = 1; eret_valid = 1;
    step();
    check("rst_over_exc_rv", redirect_valid, 1'b0);
    check("rst_over_exc_status", status_o, 32'h0040_FF02);
    rst = 0;
    clear_strobes();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
